// File: rtl/execute_div_pkg.sv
// Shared types for the divide execution unit: issue/writeback/feedback packs,
// divider state enum and the restoring-step and sign-fixup helpers.
package execute_div_pkg;

  localparam int XLEN  = 32;
  localparam int PHY_W = 6;
  localparam int ROB_W = 7;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  typedef enum logic [1:0] {
    div_div,
    div_divu,
    div_rem,
    div_remu
  } div_op_t;

  typedef enum logic [3:0] {
    instruction_address_misaligned = 4'd0,
    instruction_access_fault       = 4'd1,
    illegal_instruction            = 4'd2,
    breakpoint                     = 4'd3,
    load_address_misaligned        = 4'd4,
    load_access_fault              = 4'd5,
    store_address_misaligned       = 4'd6,
    store_access_fault             = 4'd7,
    environment_call_from_m_mode   = 4'd11
  } riscv_exception_t;

  typedef enum logic [1:0] {
    arg_src_reg,
    arg_src_imm,
    arg_src_disable
  } arg_src_t;

  typedef enum logic [2:0] {
    op_alu,
    op_bru,
    op_csr,
    op_div,
    op_mul,
    op_lsu
  } op_t;

  typedef enum logic [2:0] {
    op_unit_alu,
    op_unit_bru,
    op_unit_csr,
    op_unit_div,
    op_unit_mul,
    op_unit_lsu
  } op_unit_t;

  typedef struct packed {
    logic             enable;
    logic [31:0]      value;
    logic             valid;
    logic [ROB_W-1:0] rob_id;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic             has_exception;
    riscv_exception_t exception_id;
    logic [31:0]      exception_value;
    arg_src_t         arg1_src;
    logic             rs1_need_map;
    logic [PHY_W-1:0] rs1_phy;
    logic [31:0]      src1_value;
    arg_src_t         arg2_src;
    logic             rs2_need_map;
    logic [PHY_W-1:0] rs2_phy;
    logic [31:0]      src2_value;
    logic             rd_enable;
    logic             need_rename;
    logic [PHY_W-1:0] rd_phy;
    logic [11:0]      csr;
    op_t              op;
    op_unit_t         op_unit;
    div_op_t          sub_op;
  } issue_execute_pack_t;

  typedef struct packed {
    logic             enable;
    logic [31:0]      value;
    logic             valid;
    logic [ROB_W-1:0] rob_id;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic             has_exception;
    riscv_exception_t exception_id;
    logic [31:0]      exception_value;
    logic             bru_jump;
    logic [31:0]      bru_next_pc;
    arg_src_t         arg1_src;
    logic             rs1_need_map;
    logic [PHY_W-1:0] rs1_phy;
    logic [31:0]      src1_value;
    arg_src_t         arg2_src;
    logic             rs2_need_map;
    logic [PHY_W-1:0] rs2_phy;
    logic [31:0]      src2_value;
    logic             rd_enable;
    logic             need_rename;
    logic [PHY_W-1:0] rd_phy;
    logic [31:0]      rd_value;
    logic [11:0]      csr;
    logic [31:0]      csr_newvalue;
    logic             csr_newvalue_valid;
    op_t              op;
    op_unit_t         op_unit;
    div_op_t          sub_op;
  } execute_wb_pack_t;

  typedef struct packed {
    logic             enable;
    logic [PHY_W-1:0] phy_id;
    logic [31:0]      value;
  } execute_feedback_channel_t;

  typedef struct packed {
    logic enable;
    logic flush;
  } commit_feedback_pack_t;

  function automatic logic op_signed(input div_op_t op);
    return (op == div_div) | (op == div_rem);
  endfunction

  function automatic logic op_is_div(input div_op_t op);
    return (op == div_div) | (op == div_divu);
  endfunction

  // One restoring step on {rem, quo}; bit 32 of the trial difference is the borrow.
  function automatic logic [63:0] div_step(
    input logic [31:0] rem,
    input logic [31:0] quo,
    input logic [31:0] dvs
  );
    logic [32:0] t;
    logic [32:0] d;
    t = {rem, quo[31]};
    d = t - {1'b0, dvs};
    if (!d[32])
      return {d[31:0], quo[30:0], 1'b1};
    return {t[31:0], quo[30:0], 1'b0};
  endfunction

  function automatic logic [31:0] div_fixup(
    input div_op_t     op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] q,
    input logic [31:0] r
  );
    logic sgn;
    logic isd;
    sgn = op_signed(op);
    isd = op_is_div(op);
    if (b == '0)
      return isd ? 32'hFFFF_FFFF : a;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return isd ? 32'h8000_0000 : 32'h0;
    if (isd)
      return (sgn & (a[31] ^ b[31])) ? -q : q;
    return (sgn & a[31]) ? -r : r;
  endfunction

endpackage

// File: rtl/execute_div_core.sv
// Iterative unsigned restoring divider, ITER_PER_CYCLE quotient bits per cycle.
// o_done flags the cycle that resolves the final quotient bits.
module div_core
  import execute_div_pkg::*;
#(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  localparam int N = 32 / ITER_PER_CYCLE;

  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [63:0] w_acc;

  always_comb begin
    w_acc = {r_rem, r_quo};
    for (int i = 0; i < ITER_PER_CYCLE; i++)
      w_acc = div_step(w_acc[63:32], w_acc[31:0], r_dvs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= 6'(N);
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 6'd1;
      r_rem <= w_acc[63:32];
      r_quo <= w_acc[31:0];
    end
  end

  assign o_done      = (r_cnt == 6'd1);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/execute_div.sv
// RV32M divide execution unit: pops issue FIFO, runs div_core, writes back.
// Optional DIV_EARLY_OUT_EN resolves trivial divides at pop.
module execute_div
  import execute_div_pkg::*;
#(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  issue_execute_pack_t       issue_div_fifo_data_out,
  input  logic                      issue_div_fifo_data_out_valid,
  output logic                      issue_div_fifo_pop,
  output execute_wb_pack_t          div_wb_port_data_in,
  output logic                      div_wb_port_we,
  output logic                      div_wb_port_flush,
  output execute_feedback_channel_t div_execute_channel_feedback_pack,
  input  commit_feedback_pack_t     commit_feedback_pack
);

  div_state_t          r_state;
  div_state_t          w_next;
  issue_execute_pack_t r_pack;
  logic [31:0]         r_result;
  logic                r_use_core;

  logic        w_flush;
  logic        w_pop;
  logic        w_go;
  logic        w_sgn;
  logic        w_early;
  logic        w_start;
  logic        w_last;
  logic        w_fb_en;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_result;

  assign w_flush = commit_feedback_pack.enable
                 & commit_feedback_pack.flush;
  assign div_wb_port_flush = w_flush;

  assign w_pop = issue_div_fifo_data_out_valid & !w_flush
               & (r_state == DIV_IDLE | r_state == DIV_DONE);
  assign issue_div_fifo_pop = w_pop;

  assign w_go = issue_div_fifo_data_out.enable
              & issue_div_fifo_data_out.valid
              & !issue_div_fifo_data_out.has_exception;

  assign w_a   = issue_div_fifo_data_out.src1_value;
  assign w_b   = issue_div_fifo_data_out.src2_value;
  assign w_sgn = op_signed(issue_div_fifo_data_out.sub_op);

  assign w_a_mag = (w_sgn & w_a[31]) ? -w_a : w_a;
  assign w_b_mag = (w_sgn & w_b[31]) ? -w_b : w_b;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_b == '0)
                 | (w_sgn & w_a == 32'h8000_0000
                    & w_b == 32'hFFFF_FFFF)
                 | (w_b_mag > w_a_mag);
`else
  assign w_early = 1'b0;
`endif

  assign w_start = w_pop & w_go & !w_early;

  div_core #(
    .ITER_PER_CYCLE(ITER_PER_CYCLE)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst),
    .i_start    (w_start),
    .i_abort    (w_flush),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_done     (w_last),
    .o_quotient (w_q),
    .o_remainder(w_r)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= DIV_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_flush)
      w_next = DIV_IDLE;
    else if (w_pop)
      w_next = w_start ? DIV_BUSY : DIV_DONE;
    else begin
      unique case (r_state)
        DIV_BUSY: w_next = w_last ? DIV_DONE : DIV_BUSY;
        default:  w_next = DIV_IDLE;
      endcase
    end
  end

  // Early-out ops use a zero quotient and |src1| remainder; fixup covers the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pack     <= '0;
      r_result   <= '0;
      r_use_core <= 1'b0;
    end else if (w_pop) begin
      r_pack     <= issue_div_fifo_data_out;
      r_use_core <= w_start;
      r_result   <= w_go
        ? div_fixup(issue_div_fifo_data_out.sub_op,
                    w_a, w_b, 32'h0, w_a_mag)
        : 32'h0;
    end
  end

  assign w_result = r_use_core
    ? div_fixup(r_pack.sub_op, r_pack.src1_value,
                r_pack.src2_value, w_q, w_r)
    : r_result;

  assign w_fb_en = (r_state == DIV_DONE)
                 & r_pack.enable & r_pack.valid
                 & !r_pack.has_exception
                 & r_pack.rd_enable & r_pack.need_rename;

  always_comb begin
    div_wb_port_data_in = '0;
    div_execute_channel_feedback_pack = '0;
    div_wb_port_we = 1'b0;
    if (r_state == DIV_DONE) begin
      div_wb_port_we = !w_flush;
      div_wb_port_data_in.enable          = r_pack.enable;
      div_wb_port_data_in.value           = r_pack.value;
      div_wb_port_data_in.valid           = r_pack.valid;
      div_wb_port_data_in.rob_id          = r_pack.rob_id;
      div_wb_port_data_in.pc              = r_pack.pc;
      div_wb_port_data_in.imm             = r_pack.imm;
      div_wb_port_data_in.has_exception   = r_pack.has_exception;
      div_wb_port_data_in.exception_id    = r_pack.exception_id;
      div_wb_port_data_in.exception_value = r_pack.exception_value;
      div_wb_port_data_in.arg1_src        = r_pack.arg1_src;
      div_wb_port_data_in.rs1_need_map    = r_pack.rs1_need_map;
      div_wb_port_data_in.rs1_phy         = r_pack.rs1_phy;
      div_wb_port_data_in.src1_value      = r_pack.src1_value;
      div_wb_port_data_in.arg2_src        = r_pack.arg2_src;
      div_wb_port_data_in.rs2_need_map    = r_pack.rs2_need_map;
      div_wb_port_data_in.rs2_phy         = r_pack.rs2_phy;
      div_wb_port_data_in.src2_value      = r_pack.src2_value;
      div_wb_port_data_in.rd_enable       = r_pack.rd_enable;
      div_wb_port_data_in.need_rename     = r_pack.need_rename;
      div_wb_port_data_in.rd_phy          = r_pack.rd_phy;
      div_wb_port_data_in.rd_value        = w_result;
      div_wb_port_data_in.csr             = r_pack.csr;
      div_wb_port_data_in.op              = r_pack.op;
      div_wb_port_data_in.op_unit         = r_pack.op_unit;
      div_wb_port_data_in.sub_op          = r_pack.sub_op;
      if (w_fb_en) begin
        div_execute_channel_feedback_pack.enable = 1'b1;
        div_execute_channel_feedback_pack.phy_id = r_pack.rd_phy;
        div_execute_channel_feedback_pack.value  = w_result;
      end
    end
  end

endmodule

// File: tb/tb_execute_div.sv
// Directed bench for execute_div: vector table plus flush/reset/back-to-back.
// Expected latencies assume the default build (no early-out).
module tb_execute_div;
  import execute_div_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  issue_execute_pack_t       fifo_data;
  logic                      fifo_valid;
  logic                      pop;
  execute_wb_pack_t          wb;
  logic                      we;
  logic                      wb_flush;
  execute_feedback_channel_t fb;
  commit_feedback_pack_t     cm;

  int n_cmp = 0;
  int n_bad = 0;

  execute_div #(.ITER_PER_CYCLE(1)) dut (
    .clk                              (clk),
    .rst                              (rst),
    .issue_div_fifo_data_out          (fifo_data),
    .issue_div_fifo_data_out_valid    (fifo_valid),
    .issue_div_fifo_pop               (pop),
    .div_wb_port_data_in              (wb),
    .div_wb_port_we                   (we),
    .div_wb_port_flush                (wb_flush),
    .div_execute_channel_feedback_pack(fb),
    .commit_feedback_pack             (cm)
  );

  always #5 clk = ~clk;

  typedef struct {
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_op(input div_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] phy,
                          input logic rn);
    issue_execute_pack_t pk;
    pk = '0;
    pk.enable      = 1'b1;
    pk.valid       = 1'b1;
    pk.value       = 32'h0200_4033;
    pk.rob_id      = {1'b0, phy};
    pk.pc          = 32'h1000 + {26'h0, phy} * 4;
    pk.src1_value  = a;
    pk.src2_value  = b;
    pk.rd_enable   = 1'b1;
    pk.need_rename = rn;
    pk.rd_phy      = phy;
    pk.op          = op_div;
    pk.op_unit     = op_unit_div;
    pk.sub_op      = op;
    fifo_data  = pk;
    fifo_valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the pop.
  task automatic issue(output bit popped);
    popped = 1'b0;
    for (int c = 0; c < 8 && !popped; c++) begin
      @(negedge clk);
      if (pop) popped = 1'b1;
      @(posedge clk);
      #1;
    end
    fifo_valid = 1'b0;
  endtask

  // lat counts cycles from the pop cycle; returns at negedge of the we cycle.
  task automatic await_we(output int lat);
    bit hit;
    hit = 1'b0;
    lat = 1;
    while (!hit && lat <= 60) begin
      @(negedge clk);
      if (we) hit = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    if (!hit) lat = -1;
  endtask

  task automatic check_done(input string nm, input int lat,
                            input logic [31:0] exp, input logic [5:0] phy,
                            input logic fb_en);
`ifndef DIV_EARLY_OUT_EN
    chk({nm, "_lat"}, 32'(lat), 32'd33);
`endif
    if (lat < 0) begin
      chk({nm, "_timeout"}, 32'd1, 32'd0);
    end else begin
      chk({nm, "_val"}, wb.rd_value, exp);
      chk({nm, "_en"}, 32'(wb.enable), 32'd1);
      chk({nm, "_fb_en"}, 32'(fb.enable), 32'(fb_en));
      chk({nm, "_fb_val"}, fb.value, fb_en ? exp : 32'h0);
      chk({nm, "_fb_phy"}, 32'(fb.phy_id), fb_en ? 32'(phy) : 32'h0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit popped;
    int lat;
    issue_execute_pack_t pk;

    vecs[0]  = '{div_div,  32'd20,         32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFA};
    vecs[1]  = '{div_rem,  32'd20,         32'hFFFF_FFFD, 1'b1, 32'd2};
    vecs[2]  = '{div_divu, 32'd100,        32'd7,         1'b1, 32'd14};
    vecs[3]  = '{div_remu, 32'd100,        32'd7,         1'b1, 32'd2};
    vecs[4]  = '{div_remu, 32'd7,          32'd0,         1'b1, 32'd7};
    vecs[5]  = '{div_divu, 32'd7,          32'd0,         1'b1, 32'hFFFF_FFFF};
    vecs[6]  = '{div_div,  32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000};
    vecs[7]  = '{div_rem,  32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'd0};
    vecs[8]  = '{div_div,  32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFD};
    vecs[9]  = '{div_rem,  32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFF};
    vecs[10] = '{div_div,  32'hFFFF_FFEC,  32'd0,         1'b1, 32'hFFFF_FFFF};
    vecs[11] = '{div_rem,  32'hFFFF_FFEC,  32'd0,         1'b1, 32'hFFFF_FFEC};
    vecs[12] = '{div_divu, 32'hFFFF_FFFF,  32'd1,         1'b1, 32'hFFFF_FFFF};
    vecs[13] = '{div_remu, 32'hFFFF_FFFF,  32'h10,        1'b0, 32'hF};
    vecs[14] = '{div_div,  32'd5,          32'd7,         1'b1, 32'd0};
    vecs[15] = '{div_rem,  32'hFFFF_FFFB,  32'd7,         1'b1, 32'hFFFF_FFFB};

    rst        = 1'b0;
    fifo_valid = 1'b0;
    fifo_data  = '0;
    cm         = '0;

    repeat (3) @(negedge clk);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_flush", 32'(wb_flush), 32'd0);
    chk("rst_wb_zero", 32'(|wb), 32'd0);
    chk("rst_fb_zero", 32'(|fb), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      drive_op(vecs[i].op, vecs[i].a, vecs[i].b, 6'(i + 1), vecs[i].rn);
      issue(popped);
      chk($sformatf("v%0d_pop", i), 32'(popped), 32'd1);
      await_we(lat);
      check_done($sformatf("v%0d", i), lat, vecs[i].exp,
                 6'(i + 1), vecs[i].rn);
    end

    // excepting pack completes in one cycle without bypass
    pk = '0;
    pk.enable          = 1'b1;
    pk.valid           = 1'b1;
    pk.rob_id          = 7'd42;
    pk.pc              = 32'h2000;
    pk.has_exception   = 1'b1;
    pk.exception_id    = illegal_instruction;
    pk.exception_value = 32'hBAD0_0001;
    pk.src1_value      = 32'd9;
    pk.src2_value      = 32'd3;
    pk.rd_enable       = 1'b1;
    pk.need_rename     = 1'b1;
    pk.rd_phy          = 6'd20;
    pk.sub_op          = div_div;
    fifo_data  = pk;
    fifo_valid = 1'b1;
    issue(popped);
    chk("exc_pop", 32'(popped), 32'd1);
    @(negedge clk);
    chk("exc_we", 32'(we), 32'd1);
    chk("exc_en", 32'(wb.enable), 32'd1);
    chk("exc_has", 32'(wb.has_exception), 32'd1);
    chk("exc_id", 32'(wb.exception_id), 32'(illegal_instruction));
    chk("exc_val", wb.exception_value, 32'hBAD0_0001);
    chk("exc_rob", 32'(wb.rob_id), 32'd42);
    chk("exc_rd", wb.rd_value, 32'd0);
    chk("exc_fb", 32'(fb.enable), 32'd0);
    @(posedge clk);
    #1;

    // flush at busy cycle 10 discards the op; the next one pops right after
    drive_op(div_div, 32'd1000, 32'd10, 6'd30, 1'b1);
    issue(popped);
    chk("fl_pop1", 32'(popped), 32'd1);
    drive_op(div_divu, 32'd81, 32'd9, 6'd31, 1'b1);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    cm.enable = 1'b1;
    cm.flush  = 1'b1;
    @(negedge clk);
    chk("fl_flush", 32'(wb_flush), 32'd1);
    chk("fl_we", 32'(we), 32'd0);
    chk("fl_nopop", 32'(pop), 32'd0);
    @(posedge clk);
    #1;
    cm = '0;
    @(negedge clk);
    chk("fl_pop2", 32'(pop), 32'd1);
    @(posedge clk);
    #1;
    fifo_valid = 1'b0;
    await_we(lat);
    check_done("fl_next", lat, 32'd9, 6'd31, 1'b1);

    // back-to-back: second pop lands in the first op's done cycle
    drive_op(div_div, 32'hFFFF_FF9C, 32'd7, 6'd40, 1'b1);
    issue(popped);
    chk("bb_pop1", 32'(popped), 32'd1);
    drive_op(div_remu, 32'd1000, 32'd7, 6'd41, 1'b1);
    await_we(lat);
    chk("bb_pop_in_done", 32'(pop), 32'd1);
    check_done("bb_first", lat, 32'hFFFF_FFF2, 6'd40, 1'b1);
    fifo_valid = 1'b0;
    await_we(lat);
    check_done("bb_second", lat, 32'd6, 6'd41, 1'b1);

    // asynchronous reset mid-busy
    drive_op(div_divu, 32'd50, 32'd5, 6'd50, 1'b1);
    issue(popped);
    chk("rb_pop", 32'(popped), 32'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("rb_we", 32'(we), 32'd0);
    chk("rb_pop0", 32'(pop), 32'd0);
    chk("rb_wb_zero", 32'(|wb), 32'd0);
    chk("rb_fb_zero", 32'(|fb), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_op(div_divu, 32'd50, 32'd5, 6'd51, 1'b1);
    @(negedge clk);
    chk("rb_repop", 32'(pop), 32'd1);
    @(posedge clk);
    #1;
    fifo_valid = 1'b0;
    await_we(lat);
    check_done("rb_after", lat, 32'd10, 6'd51, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
